mux4_seq: RTL and testbench
===========================

# mux4_seq

Round-robin select sequencer that sits directly upstream of the 4:1 datapath mux (`mux4`). It drives the mux select `S` from four source request lines and returns the mux output `Y` to a capture register. It presents each captured word to the downstream stage through a VALID/READY handshake. The block serialises up to four competing 32-bit sources onto one bus with fair, starvation-free arbitration.

## Interface
- `N`, 32, data width; must match the `n` of the `mux4` instance
- `CLOCK`  in  1  single clock; all state updates on rising edge
- `nRESET`  in  1  asynchronous, active-low reset
- `ENABLE`  in  1  arbitration enable; when low, no new grant is issued
- `REQ`  in  4  per-source request; bit i = source Di has a word
- `GNT`  out  4  one-hot grant; bit i = Di is being sampled this cycle
- `S`  out  2  select to `mux4`
- `Y`  in  N  output of `mux4`
- `DOUT`  out  N  captured word
- `VALID`  out  1  `DOUT` holds an unconsumed word
- `READY`  in  1  downstream accepts `DOUT`

## Operation
- FSM states: IDLE, SELECT, OUTPUT. The encoding is an enum in the package.
- IDLE
  - If `ENABLE` and `|REQ` are both true, pick the winner `w` by round-robin, starting the search at `(LAST+1) mod 4`.
  - Register `S<=w`, `GNT<=1<<w`, `LAST<=w`, and go to SELECT.
  - Otherwise stay in IDLE with `GNT=0` and `S` held.
- SELECT (exactly one cycle)
  - `GNT` is one-hot and `S` is stable, so `mux4` produces `Y=Dw` combinationally.
  - At the edge: `DOUT<=Y`, `VALID<=1`, `GNT<=0`, go to OUTPUT.
- OUTPUT
  - Hold `DOUT`/`VALID`.
  - If `READY` is high: `VALID<=0` and go to IDLE.
  - Otherwise stay in OUTPUT. `DOUT` must not change while `VALID` is high.
- Round-robin pointer `LAST` (2 bits)
  - Updated only on grant.
  - The source granted last has lowest priority on the next pick.
  - Priority wraps 3→0.
- Sources must hold `Di` stable while `GNT[i]` is high. `REQ` may drop at any time.
- A `REQ` that drops during SELECT does not cancel the capture. The word is delivered.
- If `ENABLE` falls during SELECT or OUTPUT, the current transaction completes. The block then parks in IDLE.
- `REQ` bits that are set while the block is busy are ignored until the next IDLE cycle. No request is latched.
- Reset (asynchronous, any state) sets:
  - state = IDLE
  - `S=0`, `GNT=0`, `DOUT=0`, `VALID=0`
  - `LAST=3`, so the first grant after reset favours source 0
- A mid-transaction reset drops the in-flight word silently.

## Timing
- Request-to-grant: 1 cycle. `REQ` is sampled at edge k; `GNT`/`S` are valid after edge k.
- Grant-to-valid: 1 cycle. `VALID` rises after edge k+1.
- Valid-to-release: `VALID` falls at the first edge where `READY=1`.
- Minimum transaction length is 3 cycles (IDLE, SELECT, OUTPUT with `READY` already high). Peak throughput is 1 word per 3 cycles.
- `GNT` is high for exactly one cycle per transaction. It is never high when `VALID` is high.
- All outputs are registered. There is no combinational path from `REQ`/`READY` to any output.

## Structure
- Package `mux4_seq_pkg` holds:
  - `NUM_SRC=4`
  - `SEL_W=2`
  - `typedef enum logic [1:0] {IDLE, SELECT, OUTPUT} seq_state_t`
- Sub-module `rr_pick`: purely combinational.
  - Inputs: `REQ[3:0]`, `LAST[1:0]`.
  - Outputs: `WIN[1:0]`, `ANY`.
  - Rotate the request vector, take the first set bit, un-rotate.
- `mux4` is not instantiated inside this block. It is connected beside it at the top level, with `S` out and `Y` in.

## Test plan
Each bench connects a `mux4` instance with `D0=1`, `D1=2`, `D2=3`, `D3=5`.

1. Single request after reset: `REQ=0001`, `ENABLE=1`, `READY=1` → `GNT=0001`, `S=0` after 1 cycle; `DOUT=0x1`, `VALID=1` after 2; `VALID=0` after 3.
2. Round-robin fairness: `REQ=1111` held, `READY=1` → grant order 0,1,2,3,0. `DOUT` sequence is 1,2,3,5,1, one word per 3 cycles.
3. Backpressure: `REQ=0100`, `READY=0` for 5 cycles, then 1 → `DOUT=0x3` and `VALID=1` stable through the stall; `GNT` stays 0; `VALID` clears one edge after `READY` rises.
4. Wrap and skip: `LAST=2` (after granting D2), `REQ=0011` → next grant is source 0 (`DOUT=0x1`), then source 1 (`DOUT=0x2`).
5. Enable/REQ edge cases:
   - `ENABLE=0` with `REQ=1111` → no grant for 10 cycles.
   - `ENABLE` dropping during SELECT still yields `DOUT=0x5` for source 3.
   - `REQ` deasserted during SELECT still delivers the word.
6. Async reset mid-OUTPUT: `nRESET` low between edges → `VALID`, `DOUT`, `GNT`, `S` go to 0 immediately. After release with `REQ=1111`, the first grant is source 0.

Source files
------------

// File: rtl/mux4_seq_pkg.sv
// Shared types and constants for the mux4_seq round-robin select sequencer.
// Holds the FSM state encoding and the grant one-hot helper.
package mux4_seq_pkg;

  localparam int NUM_SRC = 4;
  localparam int SEL_W   = 2;

  // Pointer value after reset: source 3 counts as last granted, so source 0 wins first.
  localparam logic [SEL_W-1:0] LAST_RST = SEL_W'(NUM_SRC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SELECT = 2'd1,
    OUTPUT = 2'd2
  } seq_state_t;

  function automatic logic [NUM_SRC-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
    return NUM_SRC'(1) << sel;
  endfunction

endpackage : mux4_seq_pkg

// File: rtl/mux4_seq_rr_pick.sv
// Combinational round-robin picker: rotate requests so the source after LAST
// sits at position 0, take the first set bit, then un-rotate to a source index.
module rr_pick
  import mux4_seq_pkg::*;
(
  input  logic [NUM_SRC-1:0] REQ,
  input  logic [SEL_W-1:0]   LAST,
  output logic [SEL_W-1:0]   WIN,
  output logic               ANY
);

  logic [NUM_SRC-1:0] rot_req;
  logic [SEL_W-1:0]   start;
  logic [SEL_W-1:0]   first_ofs;

  assign start = LAST + SEL_W'(1);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    rot_req   = '0;
    first_ofs = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      rot_req[i] = REQ[start + SEL_W'(i)];
    end
    // Walk from the highest offset down so the lowest set offset is the one kept.
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (rot_req[i]) first_ofs = SEL_W'(i);
    end
  end

  assign WIN = start + first_ofs;
  assign ANY = |REQ;

endmodule : rr_pick

// File: rtl/mux4_seq.sv
// Round-robin select sequencer for an external 4:1 mux: grants one source,
// captures the mux output for a cycle, and offers it downstream via VALID/READY.
module mux4_seq
  import mux4_seq_pkg::*;
#(
  parameter int N = 32
) (
  input  logic               CLOCK,
  input  logic               nRESET,
  input  logic               ENABLE,
  input  logic [NUM_SRC-1:0] REQ,
  output logic [NUM_SRC-1:0] GNT,
  output logic [SEL_W-1:0]   S,
  input  logic [N-1:0]       Y,
  output logic [N-1:0]       DOUT,
  output logic               VALID,
  input  logic               READY
);

  seq_state_t         state_q, state_d;
  logic [SEL_W-1:0]   s_q, s_d;
  logic [NUM_SRC-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0]   last_q, last_d;
  logic [N-1:0]       dout_q, dout_d;
  logic               valid_q, valid_d;

  logic [SEL_W-1:0]   win;
  logic               any_req;

  rr_pick u_rr_pick (
    .REQ  (REQ),
    .LAST (last_q),
    .WIN  (win),
    .ANY  (any_req)
  );

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    gnt_d   = '0;
    last_d  = last_q;
    dout_d  = dout_q;
    valid_d = valid_q;

    unique case (state_q)
      IDLE: begin
        if (ENABLE && any_req) begin
          s_d     = win;
          gnt_d   = sel_onehot(win);
          last_d  = win;
          state_d = SELECT;
        end
      end
      // Grant and select are both registered, so Y already reflects the winner here.
      SELECT: begin
        dout_d  = Y;
        valid_d = 1'b1;
        state_d = OUTPUT;
      end
      OUTPUT: begin
        if (READY) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK or negedge nRESET) begin
    if (!nRESET) begin
      state_q <= IDLE;
      s_q     <= '0;
      gnt_q   <= '0;
      last_q  <= LAST_RST;
      dout_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      s_q     <= s_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
    end
  end

  assign GNT   = gnt_q;
  assign S     = s_q;
  assign DOUT  = dout_q;
  assign VALID = valid_q;

endmodule : mux4_seq

// File: tb/tb_mux4_seq.sv
// Self-checking bench for mux4_seq: a 4:1 mux model with D0=1, D1=2, D2=3, D3=5
// feeds Y; a vector table covers the steady flows, hand sequences the corner cases.
module tb_mux4_seq;

  localparam int N = 32;

  logic         clk;
  logic         rst_n;
  logic         enable;
  logic [3:0]   req;
  logic [3:0]   gnt;
  logic [1:0]   s;
  logic [N-1:0] y;
  logic [N-1:0] dout;
  logic         valid;
  logic         ready;

  int checks;
  int errors;

  mux4_seq #(.N(N)) dut (
    .CLOCK  (clk),
    .nRESET (rst_n),
    .ENABLE (enable),
    .REQ    (req),
    .GNT    (gnt),
    .S      (s),
    .Y      (y),
    .DOUT   (dout),
    .VALID  (valid),
    .READY  (ready)
  );

  always_comb begin
    y = '0;
    case (s)
      2'd0: y = 32'd1;
      2'd1: y = 32'd2;
      2'd2: y = 32'd3;
      2'd3: y = 32'd5;
      default: y = '0;
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit           do_reset;
    logic         en;
    logic [3:0]   rq;
    logic         rdy;
    logic [3:0]   exp_gnt;
    logic [1:0]   exp_s;
    logic         exp_valid;
    logic [N-1:0] exp_dout;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [N-1:0] actual, input logic [N-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic reset_dut();
    rst_n  = 1'b0;
    enable = 1'b0;
    req    = '0;
    ready  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input bit r, input logic e, input logic [3:0] q, input logic rd,
                     input logic [3:0] g, input logic [1:0] sl, input logic v, input logic [N-1:0] d);
    vecs.push_back('{r, e, q, rd, g, sl, v, d});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b1;
    enable = 1'b0;
    req    = '0;
    ready  = 1'b0;

    // Single request after reset.
    add(1, 1, 4'b0001, 1, 4'b0001, 0, 0, 0);
    add(0, 1, 4'b0001, 1, 4'b0000, 0, 1, 1);
    add(0, 1, 4'b0000, 1, 4'b0000, 0, 0, 1);
    // Fairness with all requests held: 0,1,2,3,0.
    add(1, 1, 4'b1111, 1, 4'b0001, 0, 0, 0);
    add(0, 1, 4'b1111, 1, 4'b0000, 0, 1, 1);
    add(0, 1, 4'b1111, 1, 4'b0000, 0, 0, 1);
    add(0, 1, 4'b1111, 1, 4'b0010, 1, 0, 1);
    add(0, 1, 4'b1111, 1, 4'b0000, 1, 1, 2);
    add(0, 1, 4'b1111, 1, 4'b0000, 1, 0, 2);
    add(0, 1, 4'b1111, 1, 4'b0100, 2, 0, 2);
    add(0, 1, 4'b1111, 1, 4'b0000, 2, 1, 3);
    add(0, 1, 4'b1111, 1, 4'b0000, 2, 0, 3);
    add(0, 1, 4'b1111, 1, 4'b1000, 3, 0, 3);
    add(0, 1, 4'b1111, 1, 4'b0000, 3, 1, 5);
    add(0, 1, 4'b1111, 1, 4'b0000, 3, 0, 5);
    add(0, 1, 4'b1111, 1, 4'b0001, 0, 0, 5);
    add(0, 1, 4'b1111, 1, 4'b0000, 0, 1, 1);
    add(0, 1, 4'b0000, 1, 4'b0000, 0, 0, 1);
    // Backpressure on source 2; REQ held during the stall must not regrant.
    add(0, 1, 4'b0100, 0, 4'b0100, 2, 0, 1);
    add(0, 1, 4'b0100, 0, 4'b0000, 2, 1, 3);
    for (int i = 0; i < 5; i++) add(0, 1, 4'b0100, 0, 4'b0000, 2, 1, 3);
    add(0, 1, 4'b0000, 1, 4'b0000, 2, 0, 3);
    // Wrap and skip: LAST=2, REQ=0011 gives source 0 then source 1.
    add(0, 1, 4'b0011, 1, 4'b0001, 0, 0, 3);
    add(0, 1, 4'b0011, 1, 4'b0000, 0, 1, 1);
    add(0, 1, 4'b0011, 1, 4'b0000, 0, 0, 1);
    add(0, 1, 4'b0011, 1, 4'b0010, 1, 0, 1);
    add(0, 1, 4'b0011, 1, 4'b0000, 1, 1, 2);
    add(0, 1, 4'b0000, 1, 4'b0000, 1, 0, 2);

    // Reset state.
    reset_dut();
    check("reset_gnt", N'(gnt), 0);
    check("reset_s", N'(s), 0);
    check("reset_valid", N'(valid), 0);
    check("reset_dout", dout, 0);

    foreach (vecs[i]) begin
      if (vecs[i].do_reset) reset_dut();
      enable = vecs[i].en;
      req    = vecs[i].rq;
      ready  = vecs[i].rdy;
      step();
      check($sformatf("vec%0d_gnt", i), N'(gnt), N'(vecs[i].exp_gnt));
      check($sformatf("vec%0d_s", i), N'(s), N'(vecs[i].exp_s));
      check($sformatf("vec%0d_valid", i), N'(valid), N'(vecs[i].exp_valid));
      check($sformatf("vec%0d_dout", i), dout, vecs[i].exp_dout);
    end

    // ENABLE low blocks all grants.
    reset_dut();
    enable = 1'b0;
    req    = 4'b1111;
    ready  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("disabled_gnt_c%0d", i), N'(gnt), 0);
      check($sformatf("disabled_valid_c%0d", i), N'(valid), 0);
    end

    // ENABLE drops during SELECT: source 3 word still delivered, then block parks.
    reset_dut();
    enable = 1'b1;
    req    = 4'b1000;
    ready  = 1'b1;
    step();
    check("endrop_gnt", N'(gnt), 4'b1000);
    check("endrop_s", N'(s), 3);
    enable = 1'b0;
    req    = 4'b1111;
    step();
    check("endrop_valid", N'(valid), 1);
    check("endrop_dout", dout, 5);
    check("endrop_gnt_off", N'(gnt), 0);
    step();
    check("endrop_release", N'(valid), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("endrop_parked_gnt_c%0d", i), N'(gnt), 0);
      check($sformatf("endrop_parked_valid_c%0d", i), N'(valid), 0);
    end

    // REQ drops during SELECT: word still delivered.
    reset_dut();
    enable = 1'b1;
    req    = 4'b0010;
    ready  = 1'b1;
    step();
    check("reqdrop_gnt", N'(gnt), 4'b0010);
    req = 4'b0000;
    step();
    check("reqdrop_valid", N'(valid), 1);
    check("reqdrop_dout", dout, 2);
    step();
    check("reqdrop_release", N'(valid), 0);
    step();
    check("reqdrop_no_regrant", N'(gnt), 0);

    // Asynchronous reset in the middle of OUTPUT.
    reset_dut();
    enable = 1'b1;
    req    = 4'b0100;
    ready  = 1'b0;
    step();
    check("arst_pre_gnt", N'(gnt), 4'b0100);
    step();
    check("arst_pre_valid", N'(valid), 1);
    check("arst_pre_dout", dout, 3);
    check("arst_pre_s", N'(s), 2);
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_valid", N'(valid), 0);
    check("arst_dout", dout, 0);
    check("arst_gnt", N'(gnt), 0);
    check("arst_s", N'(s), 0);
    #1;
    req   = 4'b1111;
    ready = 1'b1;
    rst_n = 1'b1;
    step();
    check("arst_first_gnt", N'(gnt), 4'b0001);
    check("arst_first_s", N'(s), 0);
    step();
    check("arst_first_dout", dout, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_mux4_seq
